dff_univ_shift_reg: RTL
=======================

// Module: dff_univ_shift_reg
// PURPOSE
//  - Parametrised successor to the single-bit sync-reset D flip-flop: WIDTH-bit register with per-cycle mode select.
//  - Modes: hold, parallel load, shift left/right with serial inputs, rotate left/right.
//  - Registered true and complement outputs, serial-out taps, and a saturating count of shift operations.
//  - Used as a staging/serialiser register in the datapath and as a bench vehicle for clocked-storage tests.
// PARAMETERS
//  - WIDTH      8   register width in bits; legal range >= 2
//  - CNT_WIDTH  4   width of shift-operation counter o_shift_cnt; legal range >= 1
// PORTS
//  - clk          in   1          rising-edge clock
//  - reset        in   1          synchronous, active-high reset
//  - i_en         in   1          update enable; 0 = hold regardless of i_mode
//  - i_mode       in   3          operation select (see BEHAVIOUR)
//  - i_d          in   WIDTH      parallel load data
//  - i_sin_l      in   1          serial in, enters bit 0 on SHL
//  - i_sin_r      in   1          serial in, enters bit WIDTH-1 on SHR
//  - o_q          out  WIDTH      register contents
//  - o_qb         out  WIDTH      bitwise complement of o_q
//  - o_sout_l     out  1          o_q[WIDTH-1] (combinational from register)
//  - o_sout_r     out  1          o_q[0] (combinational from register)
//  - o_shift_cnt  out  CNT_WIDTH  saturating count of SHL/SHR/ROL/ROR ops since reset/load
// BEHAVIOUR
//  - Clock and reset: one clock domain; reset is synchronous and active-high, sampled on rising clk.
//  - Reset: o_q=0, o_qb=all ones, o_shift_cnt=0. Reset has priority over i_en and i_mode.
//  - Reset mid-operation: any in-progress shift sequence is abandoned.
//  - Latency: one cycle. A mode applied at edge N is visible on o_q after edge N.
//  - o_qb == ~o_q at all times, including during reset; never derived from a separate flop state.
//  - i_en=0: o_q and o_shift_cnt hold.
//  - i_en=1, i_mode:
//      - 3'b000 HOLD: no change.
//      - 3'b001 LOAD: o_q<=i_d; o_shift_cnt<=0.
//      - 3'b010 SHL: o_q<={o_q[WIDTH-2:0],i_sin_l}.
//      - 3'b011 SHR: o_q<={i_sin_r,o_q[WIDTH-1:1]}.
//      - 3'b100 ROL: o_q<={o_q[WIDTH-2:0],o_q[WIDTH-1]}.
//      - 3'b101 ROR: o_q<={o_q[0],o_q[WIDTH-1:1]}.
//      - 3'b110 / 3'b111: reserved; behave as HOLD (no X propagation).
//  - o_shift_cnt: +1 on each SHL/SHR/ROL/ROR; saturates at 2**CNT_WIDTH-1 (no wrap).
//  - ROL/ROR wrap-around: WIDTH consecutive rotates restore the original value.
//  - X on i_mode while i_en=1 is a protocol violation; the bench asserts against it.
// CONFIGURATION
//  - Macro DFF_USR_PARITY_EN defined:
//      - adds output o_parity (1 bit) = registered XOR of the next o_q value.
//      - o_parity is updated in the same edge as o_q, so it always matches ^o_q; reset value 0.
//  - Undefined: port o_parity absent; no parity logic.
// STRUCTURE
//  - Package dff_usr_pkg: typedef enum logic [2:0] usr_mode_e {USR_HOLD,USR_LOAD,USR_SHL,USR_SHR,USR_ROL,USR_ROR};
//    also holds the localparam USR_MODE_W=3.
//  - Sub-module dff_sync_en: 1-bit sync-reset flop with enable; instantiated WIDTH times via generate.
//    The next-state mux lives in the top module.
//  - Counter and optional parity flop are inline in the top module.
// TESTING (WIDTH=8, CNT_WIDTH=4)
//  - reset=1 for 2 cycles with random i_mode/i_d -> o_q=8'h00, o_qb=8'hFF, o_shift_cnt=0.
//  - LOAD i_d=8'hA5 -> next cycle o_q=8'hA5, o_qb=8'h5A, o_sout_l=1, o_sout_r=1.
//  - From 8'hA5: SHL with i_sin_l=0 -> 8'h4A; then SHR with i_sin_r=1 -> 8'hA5; o_shift_cnt=2.
//  - From 8'h81: 8x ROL -> 8'h81 restored; o_shift_cnt=8. Then 10 more ROR -> o_shift_cnt=15 (saturated).
//  - i_en=0 with i_mode=SHL for 3 cycles -> o_q and o_shift_cnt unchanged.
//  - i_mode=3'b110/3'b111 -> o_q unchanged.
//  - reset asserted mid ROL sequence -> o_q=0 and o_shift_cnt=0 next edge.
//  - DFF_USR_PARITY_EN: LOAD 8'h07 -> o_parity=1; SHL i_sin_l=1 -> 8'h0F, o_parity=0.
//  - 100 random cycles (mode/en/d/reset) checked each edge against a reference model; o_qb==~o_q every cycle.

Source files
------------

// File: rtl/dff_usr_pkg.sv
// Shared types for the universal shift register: mode encoding and its width.
package dff_usr_pkg;

    localparam int unsigned USR_MODE_W = 3;

    typedef enum logic [USR_MODE_W-1:0] {
        USR_HOLD = 3'b000,
        USR_LOAD = 3'b001,
        USR_SHL  = 3'b010,
        USR_SHR  = 3'b011,
        USR_ROL  = 3'b100,
        USR_ROR  = 3'b101
    } usr_mode_e;

endpackage

// File: rtl/dff_sync_en.sv
// Single-bit D flip-flop with synchronous active-high reset and update enable.
module dff_sync_en (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/load/shift/rotate) with saturating shift counter.
// Optional registered parity output when DFF_USR_PARITY_EN is defined.
module dff_univ_shift_reg
    import dff_usr_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [USR_MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]      i_d,
    input  logic                  i_sin_l,
    input  logic                  i_sin_r,
    output logic [WIDTH-1:0]      o_q,
    output logic [WIDTH-1:0]      o_qb,
    output logic                  o_sout_l,
    output logic                  o_sout_r,
    output logic [CNT_WIDTH-1:0]  o_shift_cnt
`ifdef DFF_USR_PARITY_EN
    ,
    output logic                  o_parity
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]     q_reg;
    logic [WIDTH-1:0]     q_nxt;
    logic                 is_load;
    logic                 is_shift;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Reserved encodings fall through to default and hold.
    always_comb begin
        q_nxt    = q_reg;
        is_load  = 1'b0;
        is_shift = 1'b0;
        case (i_mode)
            USR_LOAD: begin
                q_nxt   = i_d;
                is_load = 1'b1;
            end
            USR_SHL: begin
                q_nxt    = {q_reg[WIDTH-2:0], i_sin_l};
                is_shift = 1'b1;
            end
            USR_SHR: begin
                q_nxt    = {i_sin_r, q_reg[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            USR_ROL: begin
                q_nxt    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                is_shift = 1'b1;
            end
            USR_ROR: begin
                q_nxt    = {q_reg[0], q_reg[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_sync_en u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (i_en),
            .d     (q_nxt[i]),
            .q     (q_reg[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (i_en) begin
            if (is_load) begin
                cnt_q <= '0;
            end else if (is_shift && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef DFF_USR_PARITY_EN
    logic parity_q;

    // Computed from the next value so parity lands on the same edge as o_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (i_en) begin
            parity_q <= ^q_nxt;
        end
    end

    assign o_parity = parity_q;
`endif

    assign o_q         = q_reg;
    assign o_qb        = ~q_reg;
    assign o_sout_l    = q_reg[WIDTH-1];
    assign o_sout_r    = q_reg[0];
    assign o_shift_cnt = cnt_q;

endmodule
